// File: rtl/obj_pkg.sv
// Shared types for the object scanline scanner: decoded entry, fetch descriptor, FSM states.
package obj_pkg;

  localparam int OBJ_COUNT = 512;
  localparam int OBJ_WORDS = 4;
  localparam int TILE_PX   = 16;

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, EVAL, EMIT, NEXT, DONE
  } scan_state_t;

  typedef struct packed {
    logic [2:0]  layer;
    logic [8:0]  y;
    logic [1:0]  h;
    logic [1:0]  w;
    logic [15:0] code;
    logic [6:0]  color;
    logic        prio;
    logic        flipx;
    logic        flipy;
    logic [9:0]  x;
  } obj_entry_t;

  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  row;
    logic [9:0]  x;
    logic [6:0]  color;
    logic        prio;
    logic        flipx;
  } obj_desc_t;

  function automatic obj_entry_t decode_entry(input logic [15:0] w0, input logic [15:0] w1,
                                              input logic [9:0] w2, input logic [9:0] w3);
    obj_entry_t e;
    e.y     = w0[8:0];
    e.h     = w0[10:9];
    e.w     = w0[12:11];
    e.layer = w0[15:13];
    e.code  = w1;
    e.color = w2[6:0];
    e.prio  = w2[7];
    e.flipx = w2[8];
    e.flipy = w2[9];
    e.x     = w3;
    return e;
  endfunction

endpackage

// File: rtl/obj_row_decode.sv
// Combinational visibility test of one object entry against the target line; no state, no backpressure.
module obj_row_decode
  import obj_pkg::*;
(
  input  obj_entry_t  entry,
  input  logic [8:0]  target,
  output logic        visible,
  output logic [2:0]  tr,
  output logic [3:0]  row,
  output logic [3:0]  cols
);

  logic [8:0] r;
  logic [8:0] height;
  logic [2:0] mask;
  logic       unused_fields;

  assign unused_fields = ^{entry.layer, entry.color, entry.prio, entry.flipx, entry.x};

  always_comb begin
    r       = target - entry.y;
    height  = 9'd16 << entry.h;
    mask    = 3'((4'd1 << entry.h) - 4'd1);
    visible = (entry.code != 16'd0) && (r < height);
    cols    = 4'd1 << entry.w;
    tr      = r[6:4] & mask;
    row     = r[3:0];
    // vertical flip mirrors both the tile within the sprite and the row within the tile
    if (entry.flipy) begin
      tr  = mask - tr;
      row = ~r[3:0];
    end
  end

endmodule

// File: rtl/obj_line_scanner.sv
// Scans 512 object entries per line, emits one registered descriptor per visible 16-px column; 6 ce-cycles line_start->first valid.
// Descriptor held stable while desc_ready=0; optional OBJ_SCAN_LAYER_FILTER_EN adds layer_mask.
module obj_line_scanner
  import obj_pkg::*;
#(
  parameter int MAX_PER_LINE = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        line_start,
  input  logic [8:0]  vcount,
`ifdef OBJ_SCAN_LAYER_FILTER_EN
  input  logic [7:0]  layer_mask,
`endif
  input  logic        obj_busy,
  output logic [10:0] obj_ram_addr,
  input  logic [15:0] obj_ram_data,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [15:0] desc_code,
  output logic [3:0]  desc_row,
  output logic [9:0]  desc_x,
  output logic [6:0]  desc_color,
  output logic        desc_prio,
  output logic        desc_flipx,
  output logic        scan_done,
  output logic        line_overflow,
  output logic        line_overrun
);

  scan_state_t state, state_n;
  logic [8:0]  target, index;
  logic [15:0] w0_q, w1_q;
  logic [9:0]  w2_q, w3_q;
  logic [2:0]  col, col_sel, code_col, last_col, tr;
  logic [3:0]  row, cols;
  logic [7:0]  count;
  logic [8:0]  count_inc;
  logic        budget_hit, active, accept, vis_raw, entry_vis;
  obj_entry_t  ent;
  obj_desc_t   desc_q, desc_n;

  // w3 is still on the read bus during EVAL, so the first descriptor is built from it directly
  assign ent = decode_entry(w0_q, w1_q, w2_q, (state == EVAL) ? obj_ram_data[9:0] : w3_q);

  obj_row_decode u_decode (
    .entry   (ent),
    .target  (target),
    .visible (vis_raw),
    .tr      (tr),
    .row     (row),
    .cols    (cols)
  );

`ifdef OBJ_SCAN_LAYER_FILTER_EN
  assign entry_vis = vis_raw && layer_mask[ent.layer];
`else
  assign entry_vis = vis_raw;
`endif

  assign last_col   = 3'(cols - 4'd1);
  assign col_sel    = (state == EVAL) ? 3'd0 : col + 3'd1;
  assign code_col   = ent.flipx ? last_col - col_sel : col_sel;
  assign count_inc  = {1'b0, count} + 9'd1;
  assign budget_hit = (count_inc == 9'(MAX_PER_LINE));
  assign active     = (state != IDLE) && (state != DONE);
  assign accept     = desc_valid && desc_ready;

  always_comb begin
    desc_n       = '0;
    desc_n.code  = ent.code + {10'd0, code_col, 3'b000} + {13'd0, tr};
    desc_n.row   = row;
    desc_n.x     = ent.x + {3'd0, col_sel, 4'd0};
    desc_n.color = ent.color;
    desc_n.prio  = ent.prio;
    desc_n.flipx = ent.flipx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= IDLE;
    else if (ce) state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (line_start)            state_n = RD0;
    else if (obj_busy && active) state_n = DONE;
    else begin
      case (state)
        RD0:  state_n = RD1;
        RD1:  state_n = RD2;
        RD2:  state_n = RD3;
        RD3:  state_n = EVAL;
        EVAL: state_n = entry_vis ? EMIT : NEXT;
        EMIT: begin
          if (accept) begin
            if (budget_hit)           state_n = DONE;
            else if (col == last_col) state_n = NEXT;
          end
        end
        NEXT: state_n = (index == 9'(OBJ_COUNT - 1)) ? DONE : RD0;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    obj_ram_addr = {index, 2'd0};
    desc_valid   = 1'b0;
    scan_done    = 1'b0;
    case (state)
      RD1:  obj_ram_addr = {index, 2'd1};
      RD2:  obj_ram_addr = {index, 2'd2};
      RD3:  obj_ram_addr = {index, 2'd3};
      EMIT: desc_valid   = !obj_busy;
      DONE: scan_done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target        <= '0;
      index         <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      w3_q          <= '0;
      col           <= '0;
      count         <= '0;
      desc_q        <= '0;
      line_overflow <= 1'b0;
      line_overrun  <= 1'b0;
    end else if (ce) begin
      if (line_start) begin
        target        <= vcount + 9'd1;
        index         <= '0;
        count         <= '0;
        line_overflow <= 1'b0;
        line_overrun  <= active;
      end else begin
        case (state)
          RD1:  w0_q <= obj_ram_data;
          RD2:  w1_q <= obj_ram_data;
          RD3:  w2_q <= obj_ram_data[9:0];
          EVAL: begin
            w3_q   <= obj_ram_data[9:0];
            col    <= '0;
            desc_q <= desc_n;
          end
          EMIT: begin
            if (accept) begin
              count <= count_inc[7:0];
              if (budget_hit) line_overflow <= 1'b1;
              else if (col != last_col) begin
                col    <= col_sel;
                desc_q <= desc_n;
              end
            end
          end
          NEXT: if (!obj_busy && index != 9'(OBJ_COUNT - 1)) index <= index + 9'd1;
          default: ;
        endcase
      end
    end
  end

  assign desc_code  = desc_q.code;
  assign desc_row   = desc_q.row;
  assign desc_x     = desc_q.x;
  assign desc_color = desc_q.color;
  assign desc_prio  = desc_q.prio;
  assign desc_flipx = desc_q.flipx;

endmodule

// File: tb/tb_obj_line_scanner.sv
// Bench for obj_line_scanner: object RAM model plus a list-based reference of the expected descriptors per line.
module tb_obj_line_scanner;

  localparam int MAX = 96;

  logic        clk = 1'b0;
  logic        reset, ce, line_start, obj_busy, desc_ready;
  logic [8:0]  vcount;
  logic [10:0] obj_ram_addr;
  logic [15:0] obj_ram_data;
  logic        desc_valid, desc_prio, desc_flipx, scan_done, line_overflow, line_overrun;
  logic [15:0] desc_code;
  logic [3:0]  desc_row;
  logic [9:0]  desc_x;
  logic [6:0]  desc_color;

  logic [15:0] mem [0:2047];
  logic [38:0] exp_q [$];
  bit          exp_ovf;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  obj_line_scanner #(.MAX_PER_LINE(MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .line_start    (line_start),
    .vcount        (vcount),
`ifdef OBJ_SCAN_LAYER_FILTER_EN
    .layer_mask    (8'hFF),
`endif
    .obj_busy      (obj_busy),
    .obj_ram_addr  (obj_ram_addr),
    .obj_ram_data  (obj_ram_data),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_code     (desc_code),
    .desc_row      (desc_row),
    .desc_x        (desc_x),
    .desc_color    (desc_color),
    .desc_prio     (desc_prio),
    .desc_flipx    (desc_flipx),
    .scan_done     (scan_done),
    .line_overflow (line_overflow),
    .line_overrun  (line_overrun)
  );

  always @(posedge clk) if (ce) obj_ram_data <= mem[obj_ram_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] desc_now();
    return {desc_code, desc_row, desc_x, desc_color, desc_prio, desc_flipx};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'd0;
  endtask

  task automatic put_entry(input int idx, input logic [8:0] y, input logic [1:0] h, input logic [1:0] w,
                           input logic [15:0] code, input logic [6:0] color, input logic prio,
                           input logic fx, input logic fy, input logic [9:0] x);
    mem[4*idx]     = {3'd0, w, h, y};
    mem[4*idx + 1] = code;
    mem[4*idx + 2] = {6'd0, fy, fx, prio, color};
    mem[4*idx + 3] = {6'd0, x};
  endtask

  // Walks the entry list by the sprite rules and lists every descriptor the line should produce.
  task automatic build_model(input logic [8:0] tgt);
    exp_q.delete();
    exp_ovf = 0;
    for (int i = 0; i < 512; i++) begin
      int y, h, w, code, r, tiles, tr, row, cols, cc;
      logic [15:0] e0, e1, e2, e3;
      if (exp_ovf) break;
      e0 = mem[4*i]; e1 = mem[4*i + 1]; e2 = mem[4*i + 2]; e3 = mem[4*i + 3];
      y = int'(e0[8:0]); h = int'(e0[10:9]); w = int'(e0[12:11]); code = int'(e1);
      r = (int'(tgt) - y + 512) % 512;
      if (code == 0 || r >= (16 << h)) continue;
      tiles = 1 << h;
      tr = r / 16;
      row = r % 16;
      if (e2[9]) begin
        tr = tiles - 1 - tr;
        row = 15 - row;
      end
      cols = 1 << w;
      for (int c = 0; c < cols; c++) begin
        cc = e2[8] ? cols - 1 - c : c;
        exp_q.push_back({16'(code + 8*cc + tr), 4'(row), 10'(int'(e3[9:0]) + 16*c), e2[6:0], e2[7], e2[8]});
        if (exp_q.size() == MAX) begin
          exp_ovf = 1;
          break;
        end
      end
    end
  endtask

  task automatic pulse_line(input logic [8:0] tgt);
    @(posedge clk); #1;
    vcount = tgt - 9'd1; ce = 1'b1; line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic run_line(input logic [8:0] tgt, input bit rnd, input bit timed, input logic exp_orun);
    int n, acc, first_v;
    bit done;
    build_model(tgt);
    obj_busy = 1'b0; desc_ready = 1'b1;
    pulse_line(tgt);
    n = 1; acc = 0; first_v = -1; done = 0;
    while (!done && n < 30000) begin
      if (rnd) begin
        ce = ($urandom_range(0, 3) != 0);
        desc_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (desc_valid) begin
        if (first_v < 0) first_v = n;
        if (acc < exp_q.size()) chk("desc", 64'(desc_now()), 64'(exp_q[acc]));
        else chk("desc_extra", 64'(acc), 64'(exp_q.size()));
        if (ce && desc_ready) acc++;
      end
      if (scan_done) done = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("scan_done_seen", 64'(done), 64'd1);
    chk("desc_count", 64'(acc), 64'(exp_q.size()));
    if (timed) begin
      chk("first_valid_cycle", 64'(first_v), 64'd6);
      chk("done_cycle", 64'(n), 64'(6*512 + exp_q.size() + 1));
    end
    ce = 1'b1; desc_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", 64'(scan_done), 64'd0);
    chk("overflow", 64'(line_overflow), 64'(exp_ovf));
    chk("overrun", 64'(line_overrun), 64'(exp_orun));
  endtask

  task automatic fill_random(input logic [8:0] tgt, input int vis_div);
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 3) == 0) mem[4*i + 1] = 16'd0;
      if ($urandom_range(0, vis_div - 1) == 0)
        mem[4*i][8:0] = 9'(int'(tgt) - int'($urandom_range(0, 140)));
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      seen = desc_valid;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [8:0] t9;
    reset = 1'b1; ce = 1'b0; line_start = 1'b0; obj_busy = 1'b0; desc_ready = 1'b0; vcount = 9'd0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({obj_ram_addr, desc_valid, desc_code, desc_row, desc_x, desc_color,
                            desc_prio, desc_flipx, scan_done, line_overflow, line_overrun}), 64'd0);
    @(negedge clk) reset = 1'b0;
    ce = 1'b1;

    // single column, no flip
    put_entry(0, 9'd100, 2'd0, 2'd0, 16'h0200, 7'd5, 1'b0, 1'b0, 1'b0, 10'd40);
    run_line(9'd100, 0, 1, 1'b0);
    chk("t1_code", 64'(exp_q[0][38:23]), 64'h0200);

    // 32-px tall, vertically flipped
    put_entry(0, 9'd100, 2'd1, 2'd0, 16'h0200, 7'd5, 1'b1, 1'b0, 1'b1, 10'd40);
    run_line(9'd100, 0, 1, 1'b0);

    // four columns, horizontally flipped
    put_entry(0, 9'd100, 2'd0, 2'd2, 16'h0200, 7'd9, 1'b0, 1'b1, 1'b0, 10'd40);
    run_line(9'd100, 0, 1, 1'b0);

    // y near the bottom wrapping onto target line 4
    clear_mem();
    put_entry(0, 9'd500, 2'd1, 2'd0, 16'h1234, 7'd3, 1'b0, 1'b0, 1'b0, 10'd1000);
    run_line(9'd4, 0, 1, 1'b0);

    // 200 visible single-column entries against a 96 budget, random stalls and ce gaps
    clear_mem();
    t9 = 9'($urandom_range(0, 511));
    for (int i = 0; i < 200; i++) begin
      int h, r;
      h = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, (16 << h) - 1));
      put_entry(i, 9'(int'(t9) - r), 2'(h), 2'd0, 16'($urandom_range(1, 65535)), 7'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom));
    end
    run_line(t9, 1, 0, 1'b0);
    chk("budget_count", 64'(exp_q.size()), 64'(MAX));

    // fully random lines, dense and sparse
    for (int k = 0; k < 3; k++) begin
      t9 = 9'($urandom_range(0, 511));
      fill_random(t9, (k == 0) ? 3 : 25);
      run_line(t9, 1, 0, 1'b0);
    end

    // new line_start while a scan is still running
    t9 = 9'($urandom_range(0, 511));
    fill_random(t9, 25);
    pulse_line(9'(t9 + 9'd7));
    repeat (300) @(posedge clk);
    run_line(t9, 0, 0, 1'b1);

    // copy engine grabs the RAM mid-emit
    clear_mem();
    put_entry(0, 9'd100, 2'd0, 2'd2, 16'h0200, 7'd5, 1'b0, 1'b0, 1'b0, 10'd40);
    desc_ready = 1'b0;
    pulse_line(9'd100);
    wait_valid("busy_wait");
    obj_busy = 1'b1;
    #1;
    chk("busy_valid", 64'(desc_valid), 64'd0);
    @(posedge clk); #1;
    chk("busy_done", 64'(scan_done), 64'd1);
    obj_busy = 1'b0;
    @(posedge clk); #1;
    chk("busy_idle", 64'(scan_done), 64'd0);
    chk("busy_overrun", 64'(line_overrun), 64'd0);

    // asynchronous reset while a descriptor is stalled
    desc_ready = 1'b0;
    pulse_line(9'd100);
    wait_valid("rst_wait");
    reset = 1'b1;
    #1;
    chk("reset_mid_emit", 64'({obj_ram_addr, desc_valid, desc_code, desc_row, desc_x, desc_color,
                               desc_prio, desc_flipx, scan_done, line_overflow, line_overrun}), 64'd0);
    @(negedge clk) reset = 1'b0;
    run_line(9'd100, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
